// File: rtl/riscv_retire_tracer.sv
// Retire-bus trace capture: filters retired instructions into a FIFO
// tagged with sequence numbers, with sticky overflow and drop counting.
module riscv_retire_tracer #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [1:0]                 mode_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic [XLEN-1:0]            mem_addr_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       mem_wrt_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [XLEN-1:0]            out_instr_o,
    output logic [4:0]                 out_reg_addr_o,
    output logic [XLEN-1:0]            out_reg_data_o,
    output logic [XLEN-1:0]            out_mem_addr_o,
    output logic [XLEN-1:0]            out_mem_data_o,
    output logic                       out_mem_wrt_o,
    output logic [SEQ_W-1:0]           out_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [4:0]       reg_addr;
        logic [XLEN-1:0]  reg_data;
        logic [XLEN-1:0]  mem_addr;
        logic [XLEN-1:0]  mem_data;
        logic             mem_wrt;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    entry_t            wr_entry;
    entry_t            head;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;

    logic mode_ok;
    logic qual;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        mode_ok = 1'b1;
        case (mode_i)
            2'd1:    mode_ok = (reg_addr_i != 5'd0);
            2'd2:    mode_ok = mem_wrt_i;
            default: mode_ok = 1'b1;
        endcase
    end

    // Full FIFO still accepts a retire when the head drains in the same cycle
    assign qual        = update_i & en_i & ~clr_i & mode_ok;
    assign full        = (count_q == CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o & out_ready_i & ~clr_i;
    assign push        = qual & (~full | pop);
    assign drop        = qual & ~push;

    always_comb begin
        wr_entry.pc       = pc_i;
        wr_entry.instr    = instr_i;
        wr_entry.reg_addr = reg_addr_i;
        wr_entry.reg_data = reg_data_i;
        wr_entry.mem_addr = mem_addr_i;
        wr_entry.mem_data = mem_data_i;
        wr_entry.mem_wrt  = mem_wrt_i;
        wr_entry.seq      = seq_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (qual) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    assign head           = fifo_q[rd_ptr_q];
    assign out_pc_o       = head.pc;
    assign out_instr_o    = head.instr;
    assign out_reg_addr_o = head.reg_addr;
    assign out_reg_data_o = head.reg_data;
    assign out_mem_addr_o = head.mem_addr;
    assign out_mem_data_o = head.mem_data;
    assign out_mem_wrt_o  = head.mem_wrt;
    assign out_seq_o      = head.seq;
    assign count_o        = count_q;
    assign drop_cnt_o     = drop_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_riscv_retire_tracer.sv
// Bench for riscv_retire_tracer: vector table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_riscv_retire_tracer;

    localparam int DEPTH  = 4;
    localparam int SEQ_M  = 8;
    localparam int DROP_M = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, clr = 1'b0, upd = 1'b0, mw = 1'b0, rdy = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  ra = 5'd0;
    logic [31:0] pc = '0, instr = '0, rdat = '0, maddr = '0, mdata = '0;

    logic        ov, omw, oovf;
    logic [31:0] opc, oinstr, ordat, omaddr, omdata;
    logic [4:0]  ora;
    logic [2:0]  oseq;
    logic [2:0]  ocnt;
    logic [3:0]  odrop;

    int n_chk = 0;
    int n_pass = 0;

    riscv_retire_tracer #(
        .XLEN(32), .DEPTH(DEPTH), .SEQ_W(3), .DROP_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mode_i(mode),
        .update_i(upd), .pc_i(pc), .instr_i(instr), .reg_addr_i(ra),
        .reg_data_i(rdat), .mem_addr_i(maddr), .mem_data_i(mdata),
        .mem_wrt_i(mw), .out_valid_o(ov), .out_ready_i(rdy),
        .out_pc_o(opc), .out_instr_o(oinstr), .out_reg_addr_o(ora),
        .out_reg_data_o(ordat), .out_mem_addr_o(omaddr),
        .out_mem_data_o(omdata), .out_mem_wrt_o(omw), .out_seq_o(oseq),
        .count_o(ocnt), .drop_cnt_o(odrop), .overflow_o(oovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, rdat, maddr, mdata;
        logic [4:0]  ra;
        logic        mw;
        int          seq;
    } ent_t;

    ent_t q[$];
    int   m_seq, m_drop;
    bit   m_ovf;

    typedef struct {
        bit upd, en, clr;
        bit [1:0] mode;
        bit rdy;
        bit [4:0] ra;
        bit mw;
        bit [31:0] pc;
        bit ev;
        int ecnt, eseq, edrop;
        bit eovf;
        bit [31:0] epc;
    } vec_t;

    vec_t tab[14];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(bit u, bit e, bit c, bit [1:0] m, bit r,
                         bit [4:0] a, bit w, bit [31:0] p);
        upd = u; en = e; clr = c; mode = m; rdy = r; ra = a; mw = w;
        pc = p; instr = p ^ 32'h00500093; rdat = p + 32'd5;
        maddr = {p[15:0], p[15:0]}; mdata = ~p;
    endtask

    task automatic model_reset();
        q.delete();
        m_seq = 0; m_drop = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit   popd, qualif;
        ent_t e;
        if (clr) begin
            model_reset();
            return;
        end
        popd   = (q.size() > 0) && rdy;
        qualif = upd && en && (mode == 2'd1 ? ra != 0 :
                               mode == 2'd2 ? mw : 1'b1);
        if (popd) void'(q.pop_front());
        if (qualif) begin
            e.pc = pc; e.instr = instr; e.rdat = rdat; e.maddr = maddr;
            e.mdata = mdata; e.ra = ra; e.mw = mw; e.seq = m_seq;
            m_seq = (m_seq + 1) % SEQ_M;
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drop < DROP_M) m_drop++;
            end
        end
    endtask

    task automatic cmp_model();
        check("m_valid", ov, q.size() != 0);
        check("m_count", ocnt, q.size());
        check("m_drop", odrop, m_drop);
        check("m_ovf", oovf, m_ovf);
        if (q.size() != 0) begin
            check("m_pc", opc, q[0].pc);
            check("m_instr", oinstr, q[0].instr);
            check("m_ra", ora, q[0].ra);
            check("m_rdat", ordat, q[0].rdat);
            check("m_maddr", omaddr, q[0].maddr);
            check("m_mdata", omdata, q[0].mdata);
            check("m_mw", omw, q[0].mw);
            check("m_seq", oseq, q[0].seq);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        tab[0]  = '{1,1,0,0,0,5'd1,0,32'h100, 1,1,0,0,0,32'h100};
        tab[1]  = '{0,1,0,0,1,5'd1,0,32'h0,   0,0,0,0,0,32'h0};
        tab[2]  = '{1,1,0,2,0,5'd1,0,32'h200, 0,0,0,0,0,32'h0};
        tab[3]  = '{1,1,0,2,0,5'd1,1,32'h204, 1,1,1,0,0,32'h204};
        tab[4]  = '{1,1,0,2,0,5'd1,0,32'h208, 1,1,1,0,0,32'h204};
        tab[5]  = '{1,1,0,2,0,5'd1,1,32'h20c, 1,2,1,0,0,32'h204};
        tab[6]  = '{1,1,0,1,0,5'd0,1,32'h210, 1,2,1,0,0,32'h204};
        tab[7]  = '{1,1,0,3,0,5'd0,0,32'h214, 1,3,1,0,0,32'h204};
        tab[8]  = '{1,0,0,0,0,5'd1,0,32'h218, 1,3,1,0,0,32'h204};
        tab[9]  = '{0,1,0,0,1,5'd1,0,32'h0,   1,2,2,0,0,32'h20c};
        tab[10] = '{1,1,0,0,1,5'd1,0,32'h21c, 1,2,3,0,0,32'h214};
        tab[11] = '{1,1,1,0,1,5'd1,0,32'h220, 0,0,0,0,0,32'h0};
        tab[12] = '{1,1,0,0,0,5'd1,0,32'h300, 1,1,0,0,0,32'h300};
        tab[13] = '{0,1,0,0,1,5'd1,0,32'h0,   0,0,0,0,0,32'h0};

        model_reset();
        #3;
        check("rst_valid", ov, 0);
        check("rst_count", ocnt, 0);
        check("rst_drop", odrop, 0);
        check("rst_ovf", oovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tab[i]) begin
            drive(tab[i].upd, tab[i].en, tab[i].clr, tab[i].mode,
                  tab[i].rdy, tab[i].ra, tab[i].mw, tab[i].pc);
            cyc();
            check($sformatf("tab%0d_valid", i), ov, tab[i].ev);
            check($sformatf("tab%0d_count", i), ocnt, tab[i].ecnt);
            check($sformatf("tab%0d_drop", i), odrop, tab[i].edrop);
            check($sformatf("tab%0d_ovf", i), oovf, tab[i].eovf);
            if (tab[i].ev) begin
                check($sformatf("tab%0d_seq", i), oseq, tab[i].eseq);
                check($sformatf("tab%0d_pc", i), opc, tab[i].epc);
            end
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'h400 + 32'(4 * i));
            cyc();
        end
        check("ovf_count", ocnt, 4);
        check("ovf_drop", odrop, 2);
        check("ovf_flag", oovf, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_seq", oseq, i);
            drive(0, 1, 0, 0, 1, 1, 0, 0);
            cyc();
        end
        check("ovf_empty", ov, 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'h500 + 32'(4 * i));
            cyc();
        end
        drive(1, 1, 0, 0, 1, 1, 0, 32'h5aa);
        cyc();
        check("fullpop_count", ocnt, 4);
        check("fullpop_drop", odrop, 0);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_seq", oseq, i + 1);
            if (i == 3) check("fullpop_tail_pc", opc, 32'h5aa);
            drive(0, 1, 0, 0, 1, 1, 0, 0);
            cyc();
        end

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'h600 + 32'(4 * i));
            cyc();
        end
        drive(0, 1, 0, 0, 1, 1, 0, 0);
        cyc();
        check("clr_pre_count", ocnt, 3);
        check("clr_pre_drop", odrop, 5);
        drive(1, 1, 1, 0, 1, 1, 0, 32'h700);
        cyc();
        check("clr_valid", ov, 0);
        check("clr_count", ocnt, 0);
        check("clr_drop", odrop, 0);
        check("clr_ovf", oovf, 0);
        drive(1, 1, 0, 0, 0, 1, 0, 32'h704);
        cyc();
        check("clr_next_seq", oseq, 0);

        for (int i = 0; i < 24; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'h800 + 32'(i));
            cyc();
        end
        check("sat_drop", odrop, 15);
        check("sat_ovf", oovf, 1);

        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", ov, 0);
        check("arst_count", ocnt, 0);
        check("arst_drop", odrop, 0);
        check("arst_ovf", oovf, 0);
        do_reset();
        drive(1, 1, 0, 0, 0, 1, 0, 32'h900);
        cyc();
        check("arst_first_seq", oseq, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, 0, 1, 0, 32'ha00 + 32'(4 * i));
            cyc();
            check("wrap_seq", oseq, i % SEQ_M);
            check("wrap_pc", opc, 32'ha00 + 32'(4 * i));
            drive(0, 1, 0, 0, 1, 1, 0, 0);
            cyc();
            check("wrap_empty", ocnt, 0);
        end

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 49) == 0,
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom_range(0, 1)),
                  $urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_retire_tracer.md
RISCV_RETIRE_TRACER -- requirements
Module: riscv_retire_tracer

Interface
REQ-001 SHALL have parameter XLEN, default 32: core datapath width.
REQ-002 SHALL have parameter DEPTH, default 16: trace FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter SEQ_W, default 16: sequence-number width.
REQ-004 SHALL have parameter DROP_W, default 16: dropped-entry counter width.
REQ-005 SHALL have port clk_i, input, width 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_i, input, width 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en_i, input, width 1: capture enable.
REQ-008 SHALL have port clr_i, input, width 1: synchronous flush.
REQ-009 SHALL have port mode_i, input, width 2: 0=all retires, 1=register writes only, 2=memory writes only, 3=reserved, treated as 0.
REQ-010 SHALL have the retire inputs update_i (1), pc_i (XLEN), instr_i (XLEN), reg_addr_i (5), reg_data_i (XLEN), mem_addr_i (XLEN), mem_data_i (XLEN) and mem_wrt_i (1), all inputs: the core retire bus.
REQ-011 SHALL have the outputs out_valid_o (1) and out_ready_i (input, 1): drain handshake.
REQ-012 SHALL have the outputs out_pc_o, out_instr_o, out_reg_addr_o, out_reg_data_o, out_mem_addr_o, out_mem_data_o, out_mem_wrt_o and out_seq_o (SEQ_W), widths matching the retire inputs: the head entry.
REQ-013 SHALL have the outputs count_o (clog2(DEPTH)+1), drop_cnt_o (DROP_W) and overflow_o (1).

Function
REQ-014 A retire SHALL be qualified when update_i=1, en_i=1, clr_i=0 and the mode filter passes:
- mode 1 requires reg_addr_i!=0.
- mode 2 requires mem_wrt_i=1.
REQ-015 Every qualified retire SHALL consume one sequence number: it is tagged with the current seq, then seq increments modulo 2^SEQ_W, whether or not it is stored.
REQ-016 A qualified retire SHALL be written to the FIFO tail when not full, or when full and a pop occurs in the same cycle.
REQ-017 A qualified retire that is not written SHALL be dropped: drop_cnt_o increments (saturating at all-ones) and overflow_o sets (sticky).
REQ-018 A pop SHALL occur when out_valid_o=1 and out_ready_i=1; the head advances one entry.
REQ-019 out_valid_o SHALL equal (count_o!=0); the head fields are don't-care when out_valid_o=0.
REQ-020 Latency: an entry written at edge N SHALL be visible on the outputs after edge N if the FIFO was empty (one-cycle capture-to-output latency).
REQ-021 Head fields SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 count_o SHALL change by +1 on a write only, -1 on a pop only, and 0 on both or neither; it never exceeds DEPTH.
REQ-024 Simultaneous push and pop when empty: no pop occurs, because out_valid_o=0; the push is stored.
REQ-025 mode_i changes SHALL take effect on the same cycle; stored entries are unaffected.
REQ-026 clr_i=1 SHALL have priority over push and pop at the next edge:
- count, pointers, seq, drop_cnt_o and overflow_o all go to 0.
- the retire in that cycle is ignored.
REQ-027 en_i=0 SHALL neither capture nor count as a drop, and seq does not advance.

Reset
REQ-028 rst_i=1 SHALL immediately force:
- out_valid_o=0, count_o=0, drop_cnt_o=0, overflow_o=0.
- seq=0 and both pointers 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; FIFO contents need not be cleared.
REQ-030 The first qualified retire after rst_i deasserts SHALL carry out_seq_o=0.

Verification
REQ-031 Basic capture: mode 0, one retire pc=0x100, instr=0x00500093, reg_addr=1, reg_data=5, out_ready_i=0 -> next cycle:
- out_valid_o=1, out_pc_o=0x100, out_seq_o=0, count_o=1.
REQ-032 Overflow: DEPTH=4, out_ready_i=0, 6 consecutive retires -> count_o=4, drop_cnt_o=2, overflow_o=1; drain yields seq 0,1,2,3.
REQ-033 Full with simultaneous pop: DEPTH=4 full, out_ready_i=1 plus one retire in the same cycle -> count_o stays 4, drop_cnt_o unchanged, and the new entry is stored at the tail.
REQ-034 Filter: mode 2, retires with mem_wrt_i=0,1,0,1 -> 2 entries with seq 0,1; then mode 1 with reg_addr_i=0 -> nothing captured, seq unchanged.
REQ-035 Clear and reset: 3 entries stored, drop_cnt_o=5, then clr_i pulsed with a concurrent retire -> all counters 0 and out_valid_o=0; rst_i asserted mid-cycle -> out_valid_o falls before the next edge.
REQ-036 Wrap: DEPTH=4, SEQ_W=3, 10 retires each drained immediately -> out_seq_o runs 0..7,0,1 and pointers wrap with no loss.
